// File: rtl/act7_mux4to1_gl_pkg.sv
// Shared constants for the gate-level 4:1 mux: select codes and default lane count.
package act7_mux_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/act7_mux4to1_gl_if.sv
// Bundle of the mux data/select/output signals; master drives data and selects, slave returns Y/Y_q.
interface act7_mux4to1_gl_if
  import act7_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] I3;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I0;
  logic             S0;
  logic             S1;
  logic [WIDTH-1:0] Y_q;

  modport master (output I3, I2, I1, I0, S0, S1, input Y, Y_q);
  modport slave  (input I3, I2, I1, I0, S0, S1, output Y, Y_q);
endinterface

// File: rtl/act7_mux4to1_gl_slice.sv
// One-bit gate-level 4:1 mux lane; selects arrive both true and pre-inverted so
// the inverters are shared across all lanes by the parent.
module act7_mux4_slice (
  input  wire i_i0,
  input  wire i_i1,
  input  wire i_i2,
  input  wire i_i3,
  input  wire i_s0,
  input  wire i_s1,
  input  wire i_s0_n,
  input  wire i_s1_n,
  output wire o_y
);

  wire w_t0;
  wire w_t1;
  wire w_t2;
  wire w_t3;

  and u_and0 (w_t0, i_s1_n, i_s0_n, i_i0);
  and u_and1 (w_t1, i_s1_n, i_s0,   i_i1);
  and u_and2 (w_t2, i_s1,   i_s0_n, i_i2);
  and u_and3 (w_t3, i_s1,   i_s0,   i_i3);

  or  u_or   (o_y, w_t0, w_t1, w_t2, w_t3);

endmodule

// File: rtl/act7_mux4to1_gl.sv
// WIDTH-lane gate-level 4:1 mux: combinational Y (valid even in reset) plus a
// registered copy Y_q that clears asynchronously on rst_n low.
module act7_mux4to1_gl
  import act7_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output wire  [WIDTH-1:0] Y,
  input  wire  [WIDTH-1:0] I3,
  input  wire  [WIDTH-1:0] I2,
  input  wire  [WIDTH-1:0] I1,
  input  wire  [WIDTH-1:0] I0,
  input  wire              S0,
  input  wire              S1,
  input  wire              clk,
  input  wire              rst_n,
  output logic [WIDTH-1:0] Y_q
);

  wire w_s0_n;
  wire w_s1_n;

  not u_inv_s0 (w_s0_n, S0);
  not u_inv_s1 (w_s1_n, S1);

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    act7_mux4_slice u_slice (
      .i_i0   (I0[k]),
      .i_i1   (I1[k]),
      .i_i2   (I2[k]),
      .i_i3   (I3[k]),
      .i_s0   (S0),
      .i_s1   (S1),
      .i_s0_n (w_s0_n),
      .i_s1_n (w_s1_n),
      .o_y    (Y[k])
    );
  end

  logic [WIDTH-1:0] r_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= Y;
    end
  end

  assign Y_q = r_y_q;

endmodule

// File: tb/tb_act7_mux4to1_gl.sv
// Directed and randomized checks of act7_mux4to1_gl at WIDTH=1 and WIDTH=4.
`timescale 1ns/1ps
module tb_act7_mux4to1_gl;
  import act7_mux_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  act7_mux4to1_gl_if #(.WIDTH(1)) if1 ();
  act7_mux4to1_gl_if #(.WIDTH(4)) if4 ();

  act7_mux4to1_gl #(.WIDTH(1)) dut1 (
    .Y(if1.Y), .I3(if1.I3), .I2(if1.I2), .I1(if1.I1), .I0(if1.I0),
    .S0(if1.S0), .S1(if1.S1), .clk(clk), .rst_n(rst_n), .Y_q(if1.Y_q)
  );

  act7_mux4to1_gl #(.WIDTH(4)) dut4 (
    .Y(if4.Y), .I3(if4.I3), .I2(if4.I2), .I1(if4.I1), .I0(if4.I0),
    .S0(if4.S0), .S1(if4.S1), .clk(clk), .rst_n(rst_n), .Y_q(if4.Y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick entry {S1,S0} out of the list of data inputs.
  function automatic logic [3:0] ref_mux(input logic [3:0] i0, input logic [3:0] i1,
                                         input logic [3:0] i2, input logic [3:0] i3,
                                         input logic s1, input logic s0);
    logic [3:0] ins [4];
    ins[0] = i0; ins[1] = i1; ins[2] = i2; ins[3] = i3;
    return ins[{s1, s0}];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref1();
    return ref_mux({3'b0, if1.I0}, {3'b0, if1.I1}, {3'b0, if1.I2}, {3'b0, if1.I3}, if1.S1, if1.S0);
  endfunction

  function automatic logic [3:0] ref4();
    return ref_mux(if4.I0, if4.I1, if4.I2, if4.I3, if4.S1, if4.S0);
  endfunction

  initial begin
    logic [5:0]  v;
    logic [3:0]  exp_q1;
    logic [3:0]  exp_q4;
    logic [1:0]  sels [4];
    logic [3:0]  exp4 [4];

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    if1.I0 = 1'b0; if1.I1 = 1'b0; if1.I2 = 1'b0; if1.I3 = 1'b0; if1.S0 = 1'b0; if1.S1 = 1'b0;
    if4.I0 = 4'h0; if4.I1 = 4'h0; if4.I2 = 4'h0; if4.I3 = 4'h0; if4.S0 = 1'b0; if4.S1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_yq1", {3'b0, if1.Y_q}, 4'h0);
    check("reset_yq4", if4.Y_q, 4'h0);

    // Exhaustive sweep while held in reset: Y must still be live.
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      {if1.S1, if1.S0, if1.I0, if1.I1, if1.I2, if1.I3} = v;
      #1;
      check($sformatf("sweep_%0d", i), {3'b0, if1.Y}, ref1());
      if (i == 0)  check("spot_0",  {3'b0, if1.Y}, 4'h0);
      if (i == 1)  check("spot_1",  {3'b0, if1.Y}, 4'h0);
      if (i == 8)  check("spot_8",  {3'b0, if1.Y}, 4'h1);
      if (i == 20) check("spot_20", {3'b0, if1.Y}, 4'h1);
      if (i == 48) check("spot_48", {3'b0, if1.Y}, 4'h0);
      if (i == 49) check("spot_49", {3'b0, if1.Y}, 4'h1);
      if (i == 63) check("spot_63", {3'b0, if1.Y}, 4'h1);
    end
    check("yq_held_in_reset", {3'b0, if1.Y_q}, 4'h0);

    // Isolation: selected I2=1, everything else toggles.
    if1.S1 = 1'b1; if1.S0 = 1'b0; if1.I2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {if1.I0, if1.I1, if1.I3} = 3'(i);
      #1;
      check($sformatf("iso_hi_%0d", i), {3'b0, if1.Y}, 4'h1);
    end
    if1.I2 = 1'b0;
    #1;
    check("iso_lo", {3'b0, if1.Y}, 4'h0);

    // Register latency: I1 rises just before a clock edge.
    {if1.S1, if1.S0} = SEL_I1;
    if1.I0 = 1'b0; if1.I1 = 1'b0; if1.I2 = 1'b0; if1.I3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("lat_pre_q", {3'b0, if1.Y_q}, 4'h0);
    #8;
    if1.I1 = 1'b1;
    #0.5;
    check("lat_y_now", {3'b0, if1.Y}, 4'h1);
    check("lat_q_before", {3'b0, if1.Y_q}, 4'h0);
    @(posedge clk);
    #1;
    check("lat_q_after", {3'b0, if1.Y_q}, 4'h1);

    // Async reset mid-cycle, then release.
    #2 rst_n = 1'b0;
    #0.5;
    check("arst_q", {3'b0, if1.Y_q}, 4'h0);
    check("arst_y", {3'b0, if1.Y}, 4'h1);
    @(posedge clk);
    #1;
    check("arst_hold", {3'b0, if1.Y_q}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release", {3'b0, if1.Y_q}, 4'h1);

    // WIDTH=4 select sweep.
    sels[0] = SEL_I0; sels[1] = SEL_I1; sels[2] = SEL_I2; sels[3] = SEL_I3;
    exp4[0] = 4'hA;   exp4[1] = 4'h5;   exp4[2] = 4'hF;   exp4[3] = 4'h0;
    if4.I0 = 4'hA; if4.I1 = 4'h5; if4.I2 = 4'hF; if4.I3 = 4'h0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      {if4.S1, if4.S0} = sels[s];
      #1;
      check($sformatf("w4_y_s%0d", s), if4.Y, exp4[s]);
      if (s > 0) check($sformatf("w4_q_lag_s%0d", s), if4.Y_q, exp4[s-1]);
      @(posedge clk);
      #1;
      check($sformatf("w4_q_s%0d", s), if4.Y_q, exp4[s]);
    end

    // Randomized traffic on both widths against the reference.
    @(negedge clk);
    exp_q1 = ref1();
    exp_q4 = ref4();
    for (int n = 0; n < 200; n++) begin
      if1.I0 = 1'($urandom); if1.I1 = 1'($urandom); if1.I2 = 1'($urandom); if1.I3 = 1'($urandom);
      if1.S0 = 1'($urandom); if1.S1 = 1'($urandom);
      if4.I0 = 4'($urandom); if4.I1 = 4'($urandom); if4.I2 = 4'($urandom); if4.I3 = 4'($urandom);
      if4.S0 = 1'($urandom); if4.S1 = 1'($urandom);
      #1;
      check($sformatf("rnd_y1_%0d", n), {3'b0, if1.Y}, ref1());
      check($sformatf("rnd_y4_%0d", n), if4.Y, ref4());
      check($sformatf("rnd_q1_%0d", n), {3'b0, if1.Y_q}, exp_q1);
      check($sformatf("rnd_q4_%0d", n), if4.Y_q, exp_q4);
      @(posedge clk);
      exp_q1 = ref1();
      exp_q4 = ref4();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
